idu1_sb_issue: RTL
==================

// Module: idu1_sb_issue
// PURPOSE
// - Parametrised decode->execute issue stage. Replaces last-issued-instruction stall heuristics
//   with a per-register scoreboard, multi-port writeback forwarding and a valid/ready handshake.
// - Sits between the IDU0 decode output / register-file read and the EXU functional units
//   (ALU/MUL/DIV/LSU). Holds one instruction in an output register until the EXU accepts it.
// PARAMETERS
// - XLEN       32   operand data width
// - NUM_REGS   32   architectural registers; RA_W = $clog2(NUM_REGS); reg 0 hardwired zero
// - NUM_WB     2    writeback ports; a higher index wins when several hit the same reg
// - NUM_UNITS  4    functional units, one-hot encoding (bit0 ALU, 1 MUL, 2 DIV, 3 LSU)
// - PAYLOAD_W  64   opaque decode payload (imm, opcode flags, pc, tag), passed through
// PORTS
// - clk           in   1              clock
// - rst           in   1              reset: synchronous, active-high
// - dec_valid     in   1              decoded instruction present
// - dec_ready     out  1              stage accepts the decoded instruction this cycle
// - dec_rs1_addr  in   RA_W           source 1 address
// - dec_rs2_addr  in   RA_W           source 2 address
// - dec_rs1_en    in   1              source 1 is used
// - dec_rs2_en    in   1              source 2 is used
// - dec_rd_addr   in   RA_W           destination address
// - dec_rd_en     in   1              destination is written
// - dec_unit      in   NUM_UNITS      target unit, one-hot
// - dec_payload   in   PAYLOAD_W      pass-through payload
// - rf_rs1_data   in   XLEN           register-file read data, source 1 (same cycle)
// - rf_rs2_data   in   XLEN           register-file read data, source 2 (same cycle)
// - wb_valid      in   NUM_WB         writeback strobe per port
// - wb_addr       in   NUM_WB*RA_W    writeback address per port
// - wb_data       in   NUM_WB*XLEN    writeback data per port
// - unit_busy     in   NUM_UNITS      unit cannot accept a new operation
// - flush         in   1              kill the held instruction
// - iss_valid     out  1              issue register holds a valid instruction
// - iss_ready     in   1              EXU accepts; transfer = iss_valid & iss_ready
// - iss_rs1_data  out  XLEN           forwarded source 1 operand
// - iss_rs2_data  out  XLEN           forwarded source 2 operand
// - iss_rd_addr   out  RA_W           destination address
// - iss_rd_en     out  1              destination is written
// - iss_unit      out  NUM_UNITS      target unit
// - iss_payload   out  PAYLOAD_W      payload
// - sb_busy       out  NUM_REGS       scoreboard state, for debug and verification
// BEHAVIOUR
// - Reset: sb_busy = 0, iss_valid = 0, all iss_* data = 0, dec_ready = 0 while rst is high.
// - Hazard exists if any of the following holds; x0 is never busy:
//   - RAW: (rs1_en & busy[rs1]) | (rs2_en & busy[rs2])
//   - WAW: rd_en & busy[rd]
//   - Structural: |(dec_unit & unit_busy)
// - dec_ready = ~hazard & (~iss_valid | iss_ready) & ~flush.
// - Accept (dec_valid & dec_ready), 1-cycle latency: the issue register loads the instruction,
//   iss_valid = 1 next cycle, and busy[rd] is set if rd_en and rd != 0.
// - Hold: iss_valid & ~iss_ready keeps the contents stable. A writeback that hits a used source
//   of the held instruction still updates that operand.
// - Transfer with no new accept: iss_valid = 0 next cycle.
// - Writeback: wb_valid[i] clears busy[wb_addr[i]] next cycle.
// - Set and clear of the same register in one cycle: the set wins.
// - Operand select at accept: a writeback hit (highest port index wins) overrides rf data.
// - Flush: iss_valid = 0 next cycle and busy[iss_rd_addr] is cleared if iss_rd_en. dec_ready = 0
//   in the flush cycle. A writeback in the same cycle still applies.
// - Reset mid-operation discards the held instruction and clears the whole scoreboard.
// CONFIGURATION
// - ISSUE_WB_BYPASS_EN defined: a same-cycle writeback to a busy register removes the RAW/WAW
//   hazard in that cycle, and its data is forwarded into the issue register.
// - ISSUE_WB_BYPASS_EN undefined: hazard evaluation uses only registered busy bits, so there is
//   one extra stall cycle after each writeback. Writeback forwarding of rf data still applies.
// TESTING
// - Reset, then dec_valid with rs1=3, rs2=4, rd=5 and unit ALU, iss_ready=1
//   -> iss_valid 1 cycle later; sb_busy[5]=1.
// - Busy[5] set, dec rs1=5 -> dec_ready=0. Then wb_valid[0], wb_addr=5, wb_data=32'hDEAD_BEEF
//   -> with bypass: accept in the same cycle, iss_rs1_data=DEADBEEF. Without bypass: accept 1 cycle later.
// - wb port0 and port1 both write reg 7 (data 1 and 2), dec rs2=7 -> iss_rs2_data=2.
// - iss_ready=0 for 3 cycles, wb to the held rs1 with 32'h1234 -> payload stable,
//   iss_rs1_data=1234, dec_ready=0.
// - unit_busy[1]=1, dec unit MUL -> stalls until busy drops. An ALU op with unit_busy[1]=1 is accepted.
// - Held rd=9, flush=1 -> iss_valid=0 and sb_busy[9]=0 next cycle. Writes to rd=0 never set busy.

Source files
------------

// File: rtl/idu1_sb_issue.sv
`default_nettype none
// ============================================================================
//  Module   : idu1_sb_issue
//  Purpose  : Decode -> execute issue stage. Tracks in-flight destination
//             registers with a per-register scoreboard, forwards writeback
//             data into operands, and holds one instruction in an output
//             register behind a valid/ready handshake towards the EXU.
//  Ports    : clk, rst             clock, synchronous active-high reset
//             dec_*_i / dec_ready_o decoded instruction + handshake
//             rf_rs{1,2}_data_i    same-cycle register-file read data
//             wb_valid/addr/data_i writeback ports (higher index wins)
//             unit_busy_i          per functional unit busy (one-hot map)
//             flush_i              kill the held instruction
//             iss_*_o / iss_ready_i issue register + handshake
//             sb_busy_o            scoreboard state
//  Config   : ISSUE_WB_BYPASS_EN - when defined, a same-cycle writeback to a
//             busy register removes the RAW/WAW hazard in that cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module idu1_sb_issue #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_WB    = 2,
    parameter int NUM_UNITS = 4,
    parameter int PAYLOAD_W = 64,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_valid_i,
    output logic                   dec_ready_o,
    input  logic [RA_W-1:0]        dec_rs1_addr_i,
    input  logic [RA_W-1:0]        dec_rs2_addr_i,
    input  logic                   dec_rs1_en_i,
    input  logic                   dec_rs2_en_i,
    input  logic [RA_W-1:0]        dec_rd_addr_i,
    input  logic                   dec_rd_en_i,
    input  logic [NUM_UNITS-1:0]   dec_unit_i,
    input  logic [PAYLOAD_W-1:0]   dec_payload_i,
    input  logic [XLEN-1:0]        rf_rs1_data_i,
    input  logic [XLEN-1:0]        rf_rs2_data_i,
    input  logic [NUM_WB-1:0]      wb_valid_i,
    input  logic [NUM_WB*RA_W-1:0] wb_addr_i,
    input  logic [NUM_WB*XLEN-1:0] wb_data_i,
    input  logic [NUM_UNITS-1:0]   unit_busy_i,
    input  logic                   flush_i,
    output logic                   iss_valid_o,
    input  logic                   iss_ready_i,
    output logic [XLEN-1:0]        iss_rs1_data_o,
    output logic [XLEN-1:0]        iss_rs2_data_o,
    output logic [RA_W-1:0]        iss_rd_addr_o,
    output logic                   iss_rd_en_o,
    output logic [NUM_UNITS-1:0]   iss_unit_o,
    output logic [PAYLOAD_W-1:0]   iss_payload_o,
    output logic [NUM_REGS-1:0]    sb_busy_o
);

    localparam logic [RA_W-1:0] ZERO_REG = '0;

    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic                 iss_valid_q;
    logic [XLEN-1:0]      iss_rs1_data_q, iss_rs2_data_q;
    logic [RA_W-1:0]      iss_rs1_addr_q, iss_rs2_addr_q, iss_rd_addr_q;
    logic                 iss_rs1_en_q, iss_rs2_en_q, iss_rd_en_q;
    logic [NUM_UNITS-1:0] iss_unit_q;
    logic [PAYLOAD_W-1:0] iss_payload_q;

    logic [NUM_REGS-1:0]  wb_clr;
    logic [NUM_REGS-1:0]  busy_eff;
    logic [XLEN-1:0]      fwd_rs1, fwd_rs2;
    logic [XLEN-1:0]      held_rs1, held_rs2;
    logic                 hazard;
    logic                 accept;

    // Writeback decode: clear mask plus operand forwarding for both the
    // incoming instruction and the one held in the issue register. Later
    // loop iterations override earlier ones, so the highest port wins.
    always_comb begin
        wb_clr   = '0;
        fwd_rs1  = rf_rs1_data_i;
        fwd_rs2  = rf_rs2_data_i;
        held_rs1 = iss_rs1_data_q;
        held_rs2 = iss_rs2_data_q;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid_i[i] && (wb_addr_i[i*RA_W +: RA_W] != ZERO_REG)) begin
                wb_clr[wb_addr_i[i*RA_W +: RA_W]] = 1'b1;
                if (wb_addr_i[i*RA_W +: RA_W] == dec_rs1_addr_i)
                    fwd_rs1 = wb_data_i[i*XLEN +: XLEN];
                if (wb_addr_i[i*RA_W +: RA_W] == dec_rs2_addr_i)
                    fwd_rs2 = wb_data_i[i*XLEN +: XLEN];
                if (iss_rs1_en_q && (wb_addr_i[i*RA_W +: RA_W] == iss_rs1_addr_q))
                    held_rs1 = wb_data_i[i*XLEN +: XLEN];
                if (iss_rs2_en_q && (wb_addr_i[i*RA_W +: RA_W] == iss_rs2_addr_q))
                    held_rs2 = wb_data_i[i*XLEN +: XLEN];
            end
        end
    end

    // Busy view used for hazard detection. Bit 0 is forced clear so x0 never
    // stalls anything.
    always_comb begin
`ifdef ISSUE_WB_BYPASS_EN
        busy_eff = busy_q & ~wb_clr;
`else
        busy_eff = busy_q;
`endif
        busy_eff[0] = 1'b0;
    end

    always_comb begin
        hazard = (dec_rs1_en_i & busy_eff[dec_rs1_addr_i])
               | (dec_rs2_en_i & busy_eff[dec_rs2_addr_i])
               | (dec_rd_en_i  & busy_eff[dec_rd_addr_i])
               | (|(dec_unit_i & unit_busy_i));
    end

    assign dec_ready_o = ~rst & ~hazard & (~iss_valid_q | iss_ready_i) & ~flush_i;
    assign accept      = dec_valid_i & dec_ready_o;

    // Scoreboard next state: writeback and flush clear first, accept sets
    // last so a same-cycle set beats a clear.
    always_comb begin
        busy_d = busy_q & ~wb_clr;
        if (flush_i && iss_valid_q && iss_rd_en_q)
            busy_d[iss_rd_addr_q] = 1'b0;
        if (accept && dec_rd_en_i)
            busy_d[dec_rd_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            iss_valid_q    <= 1'b0;
            iss_rs1_data_q <= '0;
            iss_rs2_data_q <= '0;
            iss_rs1_addr_q <= '0;
            iss_rs2_addr_q <= '0;
            iss_rs1_en_q   <= 1'b0;
            iss_rs2_en_q   <= 1'b0;
            iss_rd_addr_q  <= '0;
            iss_rd_en_q    <= 1'b0;
            iss_unit_q     <= '0;
            iss_payload_q  <= '0;
        end else begin
            busy_q <= busy_d;

            if (flush_i)
                iss_valid_q <= 1'b0;
            else if (accept)
                iss_valid_q <= 1'b1;
            else if (iss_ready_i)
                iss_valid_q <= 1'b0;

            if (accept) begin
                iss_rs1_data_q <= fwd_rs1;
                iss_rs2_data_q <= fwd_rs2;
                iss_rs1_addr_q <= dec_rs1_addr_i;
                iss_rs2_addr_q <= dec_rs2_addr_i;
                iss_rs1_en_q   <= dec_rs1_en_i;
                iss_rs2_en_q   <= dec_rs2_en_i;
                iss_rd_addr_q  <= dec_rd_addr_i;
                iss_rd_en_q    <= dec_rd_en_i;
                iss_unit_q     <= dec_unit_i;
                iss_payload_q  <= dec_payload_i;
            end else if (iss_valid_q && !iss_ready_i) begin
                // Stalled instruction keeps picking up late writebacks to
                // its own sources.
                iss_rs1_data_q <= held_rs1;
                iss_rs2_data_q <= held_rs2;
            end
        end
    end

    assign iss_valid_o    = iss_valid_q;
    assign iss_rs1_data_o = iss_rs1_data_q;
    assign iss_rs2_data_o = iss_rs2_data_q;
    assign iss_rd_addr_o  = iss_rd_addr_q;
    assign iss_rd_en_o    = iss_rd_en_q;
    assign iss_unit_o     = iss_unit_q;
    assign iss_payload_o  = iss_payload_q;
    assign sb_busy_o      = busy_q;

endmodule
`default_nettype wire
